// File: rtl/countdown_timer.sv
// Irrigation-duration countdown timer.
// Holds an M1M0:S1S0 BCD value (39:59 max), counts it down once per 1 Hz
// tick while running, drives the valve while running and flags expiry.
module countdown_timer #(
  parameter int MAX_MIN_TENS = 3,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] preset_m1,
  input  logic [3:0] preset_m0,
  input  logic [2:0] preset_s1,
  input  logic [3:0] preset_s0,
  output logic [1:0] m1,
  output logic [3:0] m0,
  output logic [2:0] s1,
  output logic [3:0] s0,
  output logic       valve_on,
  output logic       done,
  output logic       expired
);

  localparam logic [1:0] LP_M1_MAX = MAX_MIN_TENS[1:0];
  localparam logic [2:0] LP_S1_MAX = SEC_TENS_MAX[2:0];

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_EXPIRED  = 2'd3
  } state_t;

  state_t     r_state;
  logic [1:0] r_m1;
  logic [3:0] r_m0;
  logic [2:0] r_s1;
  logic [3:0] r_s0;
  logic       r_valve_on;
  logic       r_done;
  logic       r_expired;

  logic [1:0] w_load_m1;
  logic [3:0] w_load_m0;
  logic [2:0] w_load_s1;
  logic [3:0] w_load_s0;
  logic       w_is_zero;
  logic       w_is_one;
  logic [1:0] w_dec_m1;
  logic [3:0] w_dec_m0;
  logic [2:0] w_dec_s1;
  logic [3:0] w_dec_s0;
  logic       w_b_s0;
  logic       w_b_s1;
  logic       w_b_m0;

  // Out-of-range BCD units digits saturate at 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  // Seconds-tens saturates at its reload value.
  function automatic logic [2:0] clamp_s1(input logic [2:0] v);
    return (v > LP_S1_MAX) ? LP_S1_MAX : v;
  endfunction

  // Minutes-tens saturates at its top value (a no-op when it fills 2 bits).
  function automatic logic [1:0] clamp_m1(input logic [1:0] v);
    return (v > LP_M1_MAX) ? LP_M1_MAX : v;
  endfunction

  assign w_load_m1 = clamp_m1(preset_m1);
  assign w_load_m0 = clamp_bcd(preset_m0);
  assign w_load_s1 = clamp_s1(preset_s1);
  assign w_load_s0 = clamp_bcd(preset_s0);

  assign w_is_zero = (r_m1 == 2'd0) && (r_m0 == 4'd0) && (r_s1 == 3'd0) && (r_s0 == 4'd0);
  assign w_is_one  = (r_m1 == 2'd0) && (r_m0 == 4'd0) && (r_s1 == 3'd0) && (r_s0 == 4'd1);

  // Borrow chain: value minus one second, all digits resolved in one cycle.
  always_comb begin
    w_dec_s0 = r_s0;
    w_dec_s1 = r_s1;
    w_dec_m0 = r_m0;
    w_dec_m1 = r_m1;
    w_b_s0   = 1'b0;
    w_b_s1   = 1'b0;
    w_b_m0   = 1'b0;
    if (r_s0 == 4'd0) begin
      w_dec_s0 = 4'd9;
      w_b_s0   = 1'b1;
    end else begin
      w_dec_s0 = r_s0 - 4'd1;
    end
    if (w_b_s0) begin
      if (r_s1 == 3'd0) begin
        w_dec_s1 = LP_S1_MAX;
        w_b_s1   = 1'b1;
      end else begin
        w_dec_s1 = r_s1 - 3'd1;
      end
    end else begin
      w_dec_s1 = r_s1;
    end
    if (w_b_s1) begin
      if (r_m0 == 4'd0) begin
        w_dec_m0 = 4'd9;
        w_b_m0   = 1'b1;
      end else begin
        w_dec_m0 = r_m0 - 4'd1;
      end
    end else begin
      w_dec_m0 = r_m0;
    end
    if (w_b_m0 && (r_m1 != 2'd0)) begin
      w_dec_m1 = r_m1 - 2'd1;
    end else begin
      w_dec_m1 = r_m1;
    end
  end

  // Control FSM with digit registers and registered status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_m1       <= 2'd0;
      r_m0       <= 4'd0;
      r_s1       <= 3'd0;
      r_s0       <= 4'd0;
      r_valve_on <= 1'b0;
      r_done     <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (stop) begin
            r_state <= ST_IDLE;
          end else if (load) begin
            r_m1 <= w_load_m1;
            r_m0 <= w_load_m0;
            r_s1 <= w_load_s1;
            r_s0 <= w_load_s0;
          end else if (start && !w_is_zero) begin
            r_state    <= ST_RUNNING;
            r_valve_on <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUNNING: begin
          // load and start have no effect here; stop wins over tick.
          if (stop) begin
            r_state    <= ST_PAUSED;
            r_valve_on <= 1'b0;
          end else if (tick) begin
            r_m1 <= w_dec_m1;
            r_m0 <= w_dec_m0;
            r_s1 <= w_dec_s1;
            r_s0 <= w_dec_s0;
            if (w_is_one) begin
              r_state    <= ST_EXPIRED;
              r_valve_on <= 1'b0;
              r_done     <= 1'b1;
              r_expired  <= 1'b1;
            end else begin
              r_state <= ST_RUNNING;
            end
          end else begin
            r_state <= ST_RUNNING;
          end
        end
        ST_PAUSED: begin
          if (stop) begin
            r_state <= ST_PAUSED;
          end else if (load) begin
            r_m1 <= w_load_m1;
            r_m0 <= w_load_m0;
            r_s1 <= w_load_s1;
            r_s0 <= w_load_s0;
          end else if (start && !w_is_zero) begin
            r_state    <= ST_RUNNING;
            r_valve_on <= 1'b1;
          end else begin
            r_state <= ST_PAUSED;
          end
        end
        ST_EXPIRED: begin
          if (stop) begin
            r_state   <= ST_IDLE;
            r_expired <= 1'b0;
          end else if (load) begin
            r_m1      <= w_load_m1;
            r_m0      <= w_load_m0;
            r_s1      <= w_load_s1;
            r_s0      <= w_load_s0;
            r_state   <= ST_IDLE;
            r_expired <= 1'b0;
          end else begin
            r_state <= ST_EXPIRED;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_valve_on <= 1'b0;
          r_expired  <= 1'b0;
        end
      endcase
    end
  end

  assign m1       = r_m1;
  assign m0       = r_m0;
  assign s1       = r_s1;
  assign s0       = r_s0;
  assign valve_on = r_valve_on;
  assign done     = r_done;
  assign expired  = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: every driven cycle pushes the
// reference model's expected outputs; a monitor pops and compares after
// each rising edge. Directed spot checks against constants are added too.
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick  = 1'b0;
  logic       load  = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [1:0] preset_m1 = 2'd0;
  logic [3:0] preset_m0 = 4'd0;
  logic [2:0] preset_s1 = 3'd0;
  logic [3:0] preset_s0 = 4'd0;
  logic [1:0] m1;
  logic [3:0] m0;
  logic [2:0] s1;
  logic [3:0] s0;
  logic       valve_on;
  logic       done;
  logic       expired;

  countdown_timer dut (
    .clock(clock), .reset(reset), .tick(tick), .load(load), .start(start), .stop(stop),
    .preset_m1(preset_m1), .preset_m0(preset_m0), .preset_s1(preset_s1), .preset_s0(preset_s0),
    .m1(m1), .m0(m0), .s1(s1), .s0(s0),
    .valve_on(valve_on), .done(done), .expired(expired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] m1;
    logic [3:0] m0;
    logic [2:0] s1;
    logic [3:0] s0;
    logic       v;
    logic       d;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   started = 1'b0;

  // Reference model: a mode plus the remaining time in plain seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  int mdl_mode = M_IDLE;
  int mdl_secs = 0;
  bit mdl_done = 1'b0;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int preset_secs(input int pm1, input int pm0, input int ps1, input int ps0);
    return pm1 * 600 + min_i(pm0, 9) * 60 + min_i(ps1, 5) * 10 + min_i(ps0, 9);
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    x.m1 = 2'(mdl_secs / 600);
    x.m0 = 4'((mdl_secs / 60) % 10);
    x.s1 = 3'((mdl_secs % 60) / 10);
    x.s0 = 4'(mdl_secs % 10);
    x.v  = (mdl_mode == M_RUN);
    x.d  = mdl_done;
    x.e  = (mdl_mode == M_EXP);
    return x;
  endfunction

  task automatic model_step(input bit r, input bit t, input bit l, input bit st, input bit sp,
                            input int ps);
    mdl_done = 1'b0;
    if (r) begin
      mdl_mode = M_IDLE;
      mdl_secs = 0;
    end else if (mdl_mode == M_IDLE || mdl_mode == M_PAUSE) begin
      if (sp) begin
      end else if (l) begin
        mdl_secs = ps;
      end else if (st && mdl_secs != 0) begin
        mdl_mode = M_RUN;
      end
    end else if (mdl_mode == M_RUN) begin
      if (sp) begin
        mdl_mode = M_PAUSE;
      end else if (t) begin
        mdl_secs = mdl_secs - 1;
        if (mdl_secs == 0) begin
          mdl_mode = M_EXP;
          mdl_done = 1'b1;
        end
      end
    end else begin
      if (sp) begin
        mdl_mode = M_IDLE;
      end else if (l) begin
        mdl_secs = ps;
        mdl_mode = M_IDLE;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the expectation.
  task automatic step(input bit r, input bit t, input bit l, input bit st, input bit sp,
                      input logic [1:0] pm1, input logic [3:0] pm0,
                      input logic [2:0] ps1, input logic [3:0] ps0);
    @(negedge clock);
    reset = r; tick = t; load = l; start = st; stop = sp;
    preset_m1 = pm1; preset_m0 = pm0; preset_s1 = ps1; preset_s0 = ps0;
    model_step(r, t, l, st, sp, preset_secs(int'(pm1), int'(pm0), int'(ps1), int'(ps0)));
    q.push_back(model_out());
    started = 1'b1;
    @(posedge clock);
    #2;
  endtask

  task automatic idle1();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 3'd0, 4'd0);
  endtask
  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 3'd0, 4'd0);
  endtask
  task automatic do_tick();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 3'd0, 4'd0);
  endtask
  task automatic do_start();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 3'd0, 4'd0);
  endtask
  task automatic do_stop();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 3'd0, 4'd0);
  endtask
  task automatic do_load(input logic [1:0] a, input logic [3:0] b, input logic [2:0] c, input logic [3:0] d);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, b, c, d);
  endtask

  // Directed comparison of DUT digits against fixed values.
  task automatic check_time(input string name, input logic [1:0] em1, input logic [3:0] em0,
                            input logic [2:0] es1, input logic [3:0] es0);
    checks++;
    if (m1 !== em1 || m0 !== em0 || s1 !== es1 || s0 !== es0) begin
      errors++;
      $display("FAIL %s: got %0d%0d:%0d%0d expected %0d%0d:%0d%0d", name, m1, m0, s1, s0, em1, em0, es1, es0);
    end
  endtask

  // Directed comparison of DUT flags against fixed values.
  task automatic check_flags(input string name, input logic ev, input logic ed, input logic ee);
    checks++;
    if (valve_on !== ev || done !== ed || expired !== ee) begin
      errors++;
      $display("FAIL %s: got valve=%b done=%b expired=%b expected valve=%b done=%b expired=%b",
               name, valve_on, done, expired, ev, ed, ee);
    end
  endtask

  // Monitor: after each rising edge, compare DUT outputs to the queued expectation.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (m1 !== e.m1 || m0 !== e.m0 || s1 !== e.s1 || s0 !== e.s0) begin
        errors++;
        $display("FAIL sb_digits @%0t: got %0d%0d:%0d%0d expected %0d%0d:%0d%0d",
                 $time, m1, m0, s1, s0, e.m1, e.m0, e.s1, e.s0);
      end
      checks++;
      if (valve_on !== e.v || done !== e.d || expired !== e.e) begin
        errors++;
        $display("FAIL sb_flags @%0t: got v=%b d=%b e=%b expected v=%b d=%b e=%b",
                 $time, valve_on, done, expired, e.v, e.d, e.e);
      end
    end else if (started) begin
      checks++;
      errors++;
      $display("FAIL sb_empty @%0t: got no expectation queued, required one per cycle", $time);
    end
  end

  initial begin
    // Reset state
    do_reset();
    check_time("reset_digits", 2'd0, 4'd0, 3'd0, 4'd0);
    check_flags("reset_flags", 1'b0, 1'b0, 1'b0);
    idle1();

    // 00:03 down to expiry
    do_load(2'd0, 4'd0, 3'd0, 4'd3);
    do_start();
    check_flags("run_valve", 1'b1, 1'b0, 1'b0);
    do_tick();
    check_time("tick_0002", 2'd0, 4'd0, 3'd0, 4'd2);
    do_tick();
    check_time("tick_0001", 2'd0, 4'd0, 3'd0, 4'd1);
    do_tick();
    check_time("expire_digits", 2'd0, 4'd0, 3'd0, 4'd0);
    check_flags("expire_flags", 1'b0, 1'b1, 1'b1);
    idle1();
    check_flags("done_pulse_end", 1'b0, 1'b0, 1'b1);
    do_start();
    check_flags("exp_start_ignored", 1'b0, 1'b0, 1'b1);
    do_stop();
    check_flags("exp_stop_idle", 1'b0, 1'b0, 1'b0);

    // Full borrow chain
    do_load(2'd1, 4'd0, 3'd0, 4'd0);
    do_start();
    do_tick();
    check_time("borrow_1000", 2'd0, 4'd9, 3'd5, 4'd9);
    do_stop();
    do_load(2'd3, 4'd0, 3'd0, 4'd0);
    do_start();
    do_tick();
    check_time("borrow_3000", 2'd2, 4'd9, 3'd5, 4'd9);
    do_stop();

    // Pause and resume
    do_load(2'd0, 4'd0, 3'd0, 4'd5);
    do_start();
    do_tick();
    do_tick();
    do_stop();
    check_flags("paused_valve", 1'b0, 1'b0, 1'b0);
    do_tick();
    do_tick();
    do_tick();
    check_time("paused_hold", 2'd0, 4'd0, 3'd0, 4'd3);
    do_start();
    check_flags("resume_valve", 1'b1, 1'b0, 1'b0);
    do_tick();
    check_time("resume_tick", 2'd0, 4'd0, 3'd0, 4'd2);
    do_stop();

    // Preset clamping
    do_load(2'd3, 4'd15, 3'd7, 4'd12);
    check_time("clamp_3959", 2'd3, 4'd9, 3'd5, 4'd9);

    // Start at 00:00 is ignored
    do_reset();
    do_start();
    check_flags("start_zero", 1'b0, 1'b0, 1'b0);

    // Reset while running
    do_load(2'd1, 4'd2, 3'd3, 4'd4);
    do_start();
    do_tick();
    do_reset();
    check_time("run_reset", 2'd0, 4'd0, 3'd0, 4'd0);
    check_flags("run_reset_flags", 1'b0, 1'b0, 1'b0);
    do_tick();
    do_tick();
    check_time("reset_ticks", 2'd0, 4'd0, 3'd0, 4'd0);

    // Coincident inputs: start+tick in IDLE, stop+tick in RUNNING
    do_load(2'd0, 4'd0, 3'd0, 4'd2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 3'd0, 4'd0);
    check_time("start_tick", 2'd0, 4'd0, 3'd0, 4'd2);
    check_flags("start_tick_flags", 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 3'd0, 4'd0);
    check_time("stop_tick", 2'd0, 4'd0, 3'd0, 4'd2);
    check_flags("stop_tick_flags", 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] a;
      logic [3:0] b;
      logic [2:0] c;
      logic [3:0] d;
      a = 2'($urandom_range(0, 3));
      b = 4'($urandom_range(0, 15));
      c = 3'($urandom_range(0, 7));
      d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        a = 2'd0;
        b = 4'd0;
        c = 3'($urandom_range(0, 1));
      end
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 19) == 0), a, b, c, d);
    end

    idle1();
    @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expectations, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Irrigation-duration countdown timer in M1M0:S1S0 BCD form, counting 39:59 down to 00:00.
- Owns the whole digit chain: seconds units (9..0), seconds tens (5..0), minutes units (9..0) and minutes tens (3..0, the 2-bit down-from-3 digit). Generates the borrows between digits.
- Sits between the 1 Hz tick generator and the valve controller. Drives valve_on while running and pulses done when the period expires.

Parameters:
- MAX_MIN_TENS, 3, highest minutes-tens value; fixes the 2-bit width of that digit.
- SEC_TENS_MAX, 5, seconds-tens reload value on borrow.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clock-wide 1 Hz enable pulse.
- load  in  1  loads the preset digits.
- start  in  1  starts or resumes counting.
- stop  in  1  pauses a running count, or acknowledges expiry.
- preset_m1  in  2  minutes-tens preset.
- preset_m0  in  4  minutes-units preset (BCD).
- preset_s1  in  3  seconds-tens preset.
- preset_s0  in  4  seconds-units preset (BCD).
- m1  out  2  current minutes tens.
- m0  out  4  current minutes units.
- s1  out  3  current seconds tens.
- s0  out  4  current seconds units.
- valve_on  out  1  high exactly while state is RUNNING.
- done  out  1  one-cycle pulse on expiry.
- expired  out  1  level; high while state is EXPIRED.

Behaviour:
- Reset (synchronous, active-high): state IDLE, all digits 0, valve_on=0, done=0, expired=0.
- All outputs are registered. done is a single-cycle pulse; it is otherwise 0.
- States:
  - IDLE: load changes the digits. start with a nonzero value goes to RUNNING. start with 00:00 is ignored.
  - RUNNING: each tick decrements the count by one second. stop goes to PAUSED. load is ignored.
  - PAUSED: count is held and tick is ignored. start goes to RUNNING, unless the value is 00:00. load changes the digits and stays PAUSED.
  - EXPIRED: count is held at 00:00. stop goes to IDLE. load changes the digits and goes to IDLE. start is ignored.
- Priority when inputs coincide in the same cycle: reset > stop > load > start > tick.
  - start and tick in the same IDLE cycle: only the transition to RUNNING happens; the first decrement occurs on the next tick.
  - stop and tick in the same RUNNING cycle: go to PAUSED with no decrement.
- Decrement chain (all updates happen in the same edge):
  - s0: 1..9 → s0-1. 0 → 9 with borrow.
  - s1: on borrow, 1..5 → s1-1. 0 → 5 with borrow.
  - m0: on borrow, 1..9 → m0-1. 0 → 9 with borrow.
  - m1: on borrow, 3→2, 2→1, 1→0.
  - Worked example: 10:00 → 09:59 in one edge.
- Expiry: a tick in RUNNING with value 00:01 produces, at that edge:
  - value 00:00
  - state EXPIRED
  - valve_on=0, done=1 (for that cycle only), expired=1.
- A decrement from 00:00 never occurs. The RUNNING state is never entered with 00:00, so there is no wrap to 39:59.
- Preset clamping at load:
  - s0 or m0 greater than 9 loads as 9.
  - s1 greater than 5 loads as 5.
  - m1 is always valid (2 bits, 0..3).
- tick held high for consecutive cycles decrements once per cycle; no edge detection is applied.

Test Plan:
- Reset, then load 00:03, start, apply 3 ticks → digits step 00:02, 00:01, 00:00. On the third tick edge: done=1 for one cycle, expired=1, valve_on falls from 1 to 0.
- Load 10:00, start, 1 tick → 09:59. Load 30:00, start, 1 tick → 29:59. Confirms the full borrow chain.
- Load 00:05, start, 2 ticks, stop, 3 ticks, start, 1 tick → 00:03, then 00:03 held while paused, then 00:02. valve_on is 0 only during PAUSED.
- Load with preset_s0=12, preset_s1=7, preset_m0=15, preset_m1=3 → digits read 39:59.
- In IDLE at 00:00, pulse start → state stays IDLE and valve_on stays 0. In EXPIRED, pulse stop → IDLE, expired=0.
- Assert reset while RUNNING at 12:34 → next edge gives 00:00, IDLE, all flags 0. Subsequent ticks produce no change.
